// File: rtl/vga_fetch_ctrl.sv
// Frame-read scheduler for the VGA pixel path: issues bounded read bursts to keep
// the line FIFO filled, tracks returned words, and flags frame completion and late starts.
module vga_fetch_ctrl #(
  parameter int HDISP           = 800,
  parameter int VDISP           = 480,
  parameter int BURST           = 16,
  parameter int FIFO_DEPTH      = 256,
  parameter int ADDR_W          = 32,
  parameter int BYTES_PER_PIXEL = 4
) (
  input  logic                          pixel_clk,
  input  logic                          pixel_rst_n,
  input  logic                          enable,
  input  logic                          frame_start,
  input  logic [ADDR_W-1:0]             fb_base,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  output logic [$clog2(BURST):0]        rd_len,
  input  logic                          rd_ack,
  input  logic                          rd_valid,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          late_frame
);

  localparam int FRAME_WORDS = HDISP * VDISP;
  localparam int REM_W       = $clog2(FRAME_WORDS + 1);
  localparam int LEN_W       = $clog2(BURST) + 1;
  localparam int SUM_W       = $clog2(FIFO_DEPTH) + 2;

  typedef enum logic [1:0] {IDLE, ARM, REQ, DATA} state_t;

  state_t              state, state_next;
  logic [REM_W-1:0]    remaining, rem_after;
  logic [LEN_W-1:0]    data_cnt, cnt_inc, next_len;
  logic [ADDR_W-1:0]   pend_base, addr_inc;
  logic                restart_pend, restart_any;
  logic                has_space, burst_end;

  assign next_len    = (32'(remaining) >= BURST) ? LEN_W'(BURST) : LEN_W'(remaining);
  assign has_space   = (SUM_W'(fifo_level) + SUM_W'(next_len)) <= SUM_W'(FIFO_DEPTH);
  assign cnt_inc     = data_cnt + LEN_W'(1);
  assign burst_end   = (state == DATA) && rd_valid && (cnt_inc == rd_len);
  assign rem_after   = remaining - REM_W'(rd_len);
  assign addr_inc    = rd_addr + ADDR_W'(rd_len) * ADDR_W'(BYTES_PER_PIXEL);
  // A start arriving on the final word of a burst counts as already pending.
  assign restart_any = restart_pend || frame_start;

  assign rd_req = (state == REQ);
  assign busy   = (state != IDLE);

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!pixel_rst_n) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_next = state;
    case (state)
      IDLE: if (frame_start && enable) state_next = ARM;
      ARM: begin
        if (!enable)                        state_next = IDLE;
        else if (!frame_start && has_space) state_next = REQ;
      end
      REQ:  if (rd_ack) state_next = DATA;
      DATA: begin
        if (burst_end) begin
          if (restart_any)          state_next = ARM;
          else if (rem_after == '0) state_next = IDLE;
          else if (!enable)         state_next = IDLE;
          else                      state_next = ARM;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      rd_addr      <= '0;
      rd_len       <= '0;
      remaining    <= '0;
      data_cnt     <= '0;
      pend_base    <= '0;
      restart_pend <= 1'b0;
      frame_done   <= 1'b0;
      late_frame   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start && state != IDLE) late_frame <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_start && enable) begin
            rd_addr   <= fb_base;
            remaining <= REM_W'(FRAME_WORDS);
          end
        end
        ARM: begin
          if (enable && frame_start) begin
            rd_addr   <= fb_base;
            remaining <= REM_W'(FRAME_WORDS);
          end else if (enable && has_space) begin
            rd_len <= next_len;
          end
        end
        REQ: begin
          if (frame_start) begin
            restart_pend <= 1'b1;
            pend_base    <= fb_base;
          end
          if (rd_ack) data_cnt <= '0;
        end
        DATA: begin
          if (rd_valid) data_cnt <= cnt_inc;
          if (burst_end) begin
            if (restart_any) begin
              rd_addr      <= frame_start ? fb_base : pend_base;
              remaining    <= REM_W'(FRAME_WORDS);
              restart_pend <= 1'b0;
            end else begin
              rd_addr    <= addr_inc;
              remaining  <= rem_after;
              frame_done <= (rem_after == '0);
            end
          end else if (frame_start) begin
            restart_pend <= 1'b1;
            pend_base    <= fb_base;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Scoreboard bench for vga_fetch_ctrl: stimulus queues expected bursts and frame ends,
// a negedge monitor pops and compares whenever the DUT raises rd_req or frame_done.
module tb_vga_fetch_ctrl;

  localparam int HDISP = 5, VDISP = 2, BURST = 4, FIFO_DEPTH = 8, ADDR_W = 32, BPP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] fb_base = '0;
  logic [3:0]  fifo_level = '0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [2:0]  rd_len;
  logic        rd_ack = 1'b0;
  logic        rd_valid = 1'b0;
  logic        busy, frame_done, late_frame;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  len;
  } burst_t;

  burst_t      exp_bursts[$];
  logic [31:0] exp_done[$];
  int          n_checks = 0;
  int          n_errors = 0;

  vga_fetch_ctrl #(
    .HDISP(HDISP), .VDISP(VDISP), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W(ADDR_W), .BYTES_PER_PIXEL(BPP)
  ) dut (
    .pixel_clk(clk), .pixel_rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .fb_base(fb_base), .fifo_level(fifo_level), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_len(rd_len), .rd_ack(rd_ack), .rd_valid(rd_valid), .busy(busy),
    .frame_done(frame_done), .late_frame(late_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one popped expectation per rd_req assertion, held until the request drops.
  logic   req_prev = 1'b0;
  burst_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev <= 1'b0;
    end else begin
      if (rd_req && !req_prev) begin
        if (exp_bursts.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req: addr 0x%0h len %0d, expected none", rd_addr, rd_len);
          cur.addr = rd_addr; cur.len = rd_len;
        end else begin
          cur = exp_bursts.pop_front();
          check("req_addr", rd_addr, cur.addr);
          check("req_len", 32'(rd_len), 32'(cur.len));
        end
      end else if (rd_req) begin
        check("req_hold_addr", rd_addr, cur.addr);
        check("req_hold_len", 32'(rd_len), 32'(cur.len));
      end
      if (frame_done) begin
        if (exp_done.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_frame_done: addr 0x%0h, expected no pulse", rd_addr);
        end else begin
          check("done_end_addr", rd_addr, exp_done.pop_front());
        end
      end
      req_prev <= rd_req;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] base);
    frame_start = 1'b1;
    fb_base     = base;
    tick();
    frame_start = 1'b0;
  endtask

  // Queues the full 10-word frame: bursts 4, 4, 2 and the frame-end address.
  task automatic expect_frame(input logic [31:0] base, input bit with_done);
    exp_bursts.push_back('{addr: base,         len: 3'd4});
    exp_bursts.push_back('{addr: base + 32'd16, len: 3'd4});
    exp_bursts.push_back('{addr: base + 32'd32, len: 3'd2});
    if (with_done) exp_done.push_back(base + 32'd40);
  endtask

  task automatic wait_req();
    int cyc = 0;
    while (!rd_req && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!rd_req) check("req_timeout", 32'(rd_req), 32'd1);
  endtask

  task automatic serve(input int len, input int ack_delay, input bit fs_last,
                       input logic [31:0] fs_base);
    tick(ack_delay);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    for (int i = 0; i < len; i++) begin
      rd_valid = 1'b1;
      if (fs_last && i == len - 1) begin
        frame_start = 1'b1;
        fb_base     = fs_base;
      end
      tick();
      rd_valid    = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic do_burst(input int len);
    wait_req();
    serve(len, 1, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_rd_req", 32'(rd_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_len", 32'(rd_len), 0);
    check("rst_late", 32'(late_frame), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(2);

    // Basic frame: request one cycle after ARM sees space.
    expect_frame(32'h1000, 1'b1);
    start_frame(32'h1000);
    check("arm_no_req_yet", 32'(rd_req), 0);
    tick();
    check("req_latency", 32'(rd_req), 1);
    do_burst(4); do_burst(4); do_burst(2);
    tick();
    check("idle_after_frame", 32'(busy), 0);
    check("no_late_yet", 32'(late_frame), 0);

    // FIFO throttling at the exact full boundary.
    expect_frame(32'h2000, 1'b1);
    fifo_level = 4'd5;
    start_frame(32'h2000);
    tick(5);
    check("throttle_5_plus_4", 32'(rd_req), 0);
    fifo_level = 4'd4;
    tick();
    check("go_4_plus_4", 32'(rd_req), 1);
    fifo_level = 4'd6;
    serve(4, 1, 1'b0, '0);
    tick(3);
    check("throttle_6_plus_4", 32'(rd_req), 0);
    fifo_level = 4'd4;
    wait_req();
    fifo_level = 4'd6;
    serve(4, 1, 1'b0, '0);
    tick();
    check("go_6_plus_2", 32'(rd_req), 1);
    serve(2, 0, 1'b0, '0);
    fifo_level = 4'd0;
    tick();
    check("idle_after_throttled", 32'(busy), 0);

    // Late starts and enable glitch during a slow ack; last start wins.
    exp_bursts.push_back('{addr: 32'h3000, len: 3'd4});
    start_frame(32'h3000);
    wait_req();
    for (int i = 0; i < 5; i++) begin
      case (i)
        1: begin frame_start = 1'b1; fb_base = 32'h4000; end
        2: begin frame_start = 1'b0; enable = 1'b0; end
        3: begin enable = 1'b1; frame_start = 1'b1; fb_base = 32'h5000; end
        4: begin frame_start = 1'b0; fb_base = 32'hDEAD_0000; end
        default: ;
      endcase
      tick();
      check("req_held_no_ack", 32'(rd_req), 1);
    end
    check("late_set", 32'(late_frame), 1);
    serve(4, 0, 1'b0, '0);
    expect_frame(32'h5000, 1'b0);
    do_burst(4); do_burst(4);
    // Start coinciding with the final word: restart, no frame_done.
    expect_frame(32'h6000, 1'b1);
    wait_req();
    serve(2, 1, 1'b1, 32'h6000);
    do_burst(4); do_burst(4); do_burst(2);
    tick();
    check("idle_after_restart", 32'(busy), 0);
    check("late_sticky", 32'(late_frame), 1);

    // Start while disabled is ignored.
    enable = 1'b0;
    start_frame(32'h7000);
    tick(3);
    check("disabled_no_req", 32'(rd_req), 0);
    check("disabled_not_busy", 32'(busy), 0);
    enable = 1'b1;

    // Reset mid-burst clears everything immediately.
    exp_bursts.push_back('{addr: 32'h8000, len: 3'd4});
    start_frame(32'h8000);
    wait_req();
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    rd_valid = 1'b1; tick(2); rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(rd_req), 0);
    check("rst_mid_addr", rd_addr, 0);
    check("rst_mid_len", 32'(rd_len), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(frame_done), 0);
    check("rst_mid_late", 32'(late_frame), 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    expect_frame(32'h9000, 1'b1);
    start_frame(32'h9000);
    do_burst(4); do_burst(4); do_burst(2);
    tick(2);
    check("idle_after_reset_frame", 32'(busy), 0);

    check("bursts_left", 32'(exp_bursts.size()), 0);
    check("dones_left", 32'(exp_done.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
